// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: oversamples rx with clk, assembles bytes LSB first, strobes data_valid.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and the parity_err output.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TERM = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TERM = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state_q;
  logic            sync1_q;
  logic            rxs_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            data_valid_q;
  logic            frame_err_q;
  logic            busy_q;
`ifdef UART_RX_PARITY_EN
  logic            par_q;
  logic            parity_err_q;
`endif

  // Synchronizer, bit timing and frame FSM share one register block; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q      <= rx;
      rxs_q        <= sync1_q;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_TERM) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_TERM) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxs_q;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == FULL_TERM) begin
            cnt_q   <= '0;
            par_q   <= rxs_q;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == FULL_TERM) begin
            cnt_q <= '0;
            if (!rxs_q) begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            end else if ((^shift_q) != par_q) begin
              parity_err_q <= 1'b1;
              state_q      <= IDLE;
`endif
            end else begin
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
              state_q      <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // A line stuck low after a bad stop bit must not look like a new start bit.
        WAIT_HIGH: begin
          if (rxs_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: a driver serialises random frames and queues the
// expected strobe (kind, byte, cycle); a monitor pops and compares on every DUT strobe.
module tb_uart_rx_byte;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif
  localparam int LAT = CPB / 2 + (NBITS + 1) * CPB;

  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cycle;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       frameErr;
  logic       busy;
  logic       parityErr;

  exp_t       sb[$];
  logic [7:0] lastGood = 8'h00;
  int         cycleCount = 0;
  int         vectors = 0;
  int         miscompares = 0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (dataOut),
    .data_valid(dataValid),
    .frame_err (frameErr),
`ifdef UART_RX_PARITY_EN
    .parity_err(parityErr),
`endif
    .busy      (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign parityErr = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Drives one full frame and queues the response the specification's rules predict.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic parityBit);
    exp_t e;
    e.data  = b;
    e.cycle = cycleCount + 3 + LAT;
    if (!stopBit) e.kind = K_FERR;
`ifdef UART_RX_PARITY_EN
    else if ((^b) != parityBit) e.kind = K_PERR;
`endif
    else e.kind = K_VALID;
    sb.push_back(e);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = parityBit;
    repeat (CPB) @(negedge clk);
`endif
    rx = stopBit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idleHigh(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the scoreboard; data must hold otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      if (dataValid || frameErr || parityErr) begin
        exp_t e;
        int kind;
        kind = dataValid ? K_VALID : (frameErr ? K_FERR : K_PERR);
        checkOutput("one strobe at a time", int'(dataValid) + int'(frameErr) + int'(parityErr), 1);
        if (sb.size() == 0) begin
          checkOutput("unexpected strobe", kind + 16, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("strobe kind", kind, e.kind);
          checkOutput("strobe cycle", cycleCount, e.cycle);
          checkOutput("busy at strobe", int'(busy), 1);
          if (e.kind == K_VALID) begin
            checkOutput("data", int'(dataOut), int'(e.data));
            lastGood = e.data;
          end else begin
            checkOutput("data hold on error", int'(dataOut), int'(lastGood));
          end
        end
      end else begin
        checkOutput("data stable", int'(dataOut), int'(lastGood));
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       stopBit;
    logic       parityBit;
    int         waited;

    repeat (3) @(negedge clk);
    checkOutput("reset data", int'(dataOut), 0);
    checkOutput("reset data_valid", int'(dataValid), 0);
    checkOutput("reset frame_err", int'(frameErr), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset parity_err", int'(parityErr), 0);
    reset = 1'b0;
    idleHigh(5);

    // Clean byte
    applyStimulus(8'hA5, 1'b1, ^8'hA5);
    checkOutput("busy idle after clean byte", int'(busy), 0);
    idleHigh(10);

    // Glitch start
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idleHigh(20);
    checkOutput("busy after glitch", int'(busy), 0);

    // Framing error with stuck-low line
    applyStimulus(8'h3C, 1'b0, ^8'h3C);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("busy in wait-high", int'(busy), 1);
    idleHigh(6);
    checkOutput("busy after line release", int'(busy), 0);
    idleHigh(10);

    // Back-to-back frames
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    idleHigh(10);

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h07, 1'b1, 1'b0);
    idleHigh(5);
    applyStimulus(8'h07, 1'b1, 1'b1);
    idleHigh(5);
`endif

    // Reset mid-frame after three data bits of 0x81
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    lastGood = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("mid-frame reset data", int'(dataOut), 0);
    checkOutput("mid-frame reset busy", int'(busy), 0);
    checkOutput("mid-frame reset data_valid", int'(dataValid), 0);
    checkOutput("mid-frame reset frame_err", int'(frameErr), 0);
    reset = 1'b0;
    idleHigh(5);
    applyStimulus(8'h5A, 1'b1, ^8'h5A);
    idleHigh(5);

    // Randomized frames, gaps, glitches and errors
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      stopBit = ($urandom_range(0, 5) != 0);
      parityBit = ($urandom_range(0, 4) == 0) ? ~(^b) : (^b);
      applyStimulus(b, stopBit, parityBit);
      if (!stopBit) begin
        rx = 1'b0;
        repeat ($urandom_range(0, 30)) @(negedge clk);
        idleHigh($urandom_range(2, 20));
      end else if ($urandom_range(0, 5) == 0) begin
        rx = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        idleHigh(20);
      end else if ($urandom_range(0, 2) != 0) begin
        idleHigh($urandom_range(1, 40));
      end
    end
    idleHigh(5);

    waited = 0;
    while (sb.size() != 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    idleHigh(20);
    checkOutput("scoreboard drained", sb.size(), 0);
    checkOutput("busy at end", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial receive front end that turns an asynchronous 8N1 serial line into parallel bytes. It oversamples the line with the system clock, assembles each frame LSB first, and presents the byte on `data` with a one-cycle `data_valid` strobe. `data` and `data_valid` connect directly to the `d` and `enable` inputs of the downstream 8-bit enable register, so a received byte is captured on the clock edge after the strobe.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and at least 4.
- `clk` in, 1: system clock; all logic is on the rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `rx` in, 1: asynchronous serial line; idles high.
- `data` out, 8: last correctly received byte; holds its value between frames.
- `data_valid` out, 1: one-cycle strobe, asserted on the cycle `data` is updated.
- `frame_err` out, 1: one-cycle strobe, asserted when the stop bit samples low.
- `busy` out, 1: high whenever the FSM is not in IDLE.
- `parity_err` out, 1: present only with `UART_RX_PARITY_EN`; one-cycle strobe on a parity mismatch.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxs`.
- States: IDLE, START, DATA, (PARITY), STOP, WAIT_HIGH.
- A single counter `cnt` handles bit timing. A "sample" happens on the cycle `cnt` reaches its terminal value; `cnt` then clears.
- IDLE: when `rxs` = 0, go to START with `cnt` = 0.
- START: terminal value is CLKS_PER_BIT/2−1, which samples mid-bit.
  - If `rxs` = 1 at the sample, the start was a glitch: return to IDLE with no strobes.
  - Otherwise go to DATA with bit index = 0.
- DATA: terminal value is CLKS_PER_BIT−1. Each sample shifts `rxs` into bit[index] (LSB first). After index 7, go to PARITY if enabled, otherwise STOP.
- STOP: terminal value is CLKS_PER_BIT−1.
  - If `rxs` = 1: load `data` from the shift register, pulse `data_valid`, go to IDLE.
  - If `rxs` = 0: pulse `frame_err`, leave `data` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rxs` = 1, then go to IDLE. This prevents a stuck-low line from being read as repeated start bits.
- `data_valid` and `frame_err` are never asserted in the same cycle.
- Reset values: `data` = 0x00, `data_valid` = 0, `frame_err` = 0, `busy` = 0, `parity_err` = 0, state = IDLE, counters = 0.
- A reset asserted mid-frame aborts the frame with no strobes. A frame whose start bit arrives after reset deasserts is received normally.

## Timing
- The `rx` falling edge reaches `rxs` 2 cycles later. IDLE→START happens on the first edge where `rxs` = 0.
- `data_valid` asserts exactly CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the IDLE→START transition. Add CLKS_PER_BIT when parity is enabled.
- `busy` is high from the cycle after IDLE→START through the strobe cycle. It drops the following cycle, or after WAIT_HIGH exits.
- The FSM is back in IDLE one cycle after `data_valid`, ready for a start bit that immediately follows the stop bit. Back-to-back frames need no idle gap.
- `data` is registered and stable from the strobe cycle until the next valid frame. The downstream register captures it on the next rising edge.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state is inserted after DATA. It samples one bit after CLKS_PER_BIT cycles.
  - Expected parity is even: the XOR of the 8 data bits equals the parity bit.
  - On a mismatch, `parity_err` pulses in the stop-sample cycle, `data_valid` stays 0, and `data` holds.
  - The stop-bit check still applies; `frame_err` takes priority if both fail.
- `UART_RX_PARITY_EN` undefined: no PARITY state, no `parity_err` port, 10-bit frames.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- **Clean byte:** send 0xA5 (8N1) → `data` = 0xA5; exactly one `data_valid` pulse, 152 cycles after START entry; `frame_err` = 0; `busy` returns to 0.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap → two `data_valid` pulses 160 cycles apart; `data` = 0x00, then 0xFF.
- **Glitch start:** drive `rx` low for 4 cycles, then high → FSM returns to IDLE; no strobes; `data` unchanged; `busy` pulses only briefly.
- **Framing error:** send 0x3C with stop bit = 0, holding `rx` low 40 more cycles → one `frame_err` pulse; `data` keeps the prior value 0xA5; `busy` stays high until `rx` returns high.
- **Reset mid-frame:** assert `reset` after 3 data bits of 0x81 → all outputs return to reset values; next frame 0x5A gives `data` = 0x5A with one `data_valid`.
- **Parity error (`UART_RX_PARITY_EN`):** send 0x07 with parity bit 0 → `parity_err` pulses; no `data_valid`. Resend with parity bit 1 → `data` = 0x07 with `data_valid`.
